// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths and FSM state encoding for the burst RAM controller
package ram_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MEM_AW = 6;
  localparam int LEN_W  = 3;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDRAIN = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: burst address/beat counter (load latches addr/len, advance bumps low MEM_AW bits mod 64 and counts down, last = final beat)
module burst_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int LW = LEN_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] load_addr,
  input  logic [LW-1:0] load_len,
  output logic [AW-1:0] cur_addr,
  output logic          last
);
  logic [LW-1:0]     beats_left;
  logic [MEM_AW-1:0] lo_next;
  assign lo_next = cur_addr[MEM_AW-1:0] + MEM_AW'(1);
  assign last = beats_left == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_len;
    end else if (advance) begin
      cur_addr   <= {cur_addr[AW-1:MEM_AW], lo_next};
      beats_left <= beats_left - LW'(1);
    end
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: valid/ready burst master port in, one RAM access per cycle out (cen/wen/addr/din), registered read return with rdata_valid, done pulse per transaction
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DATA_W,
  parameter int LEN_W  = ram_ctrl_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              ram_cen,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t            state, next;
  logic              load, advance, last, cen, rd_pending;
  logic [ADDR_W-1:0] cur_addr;
  burst_addr_gen #(.AW(ADDR_W), .LW(LEN_W)) u_addr (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .advance   (advance),
    .load_addr (req_addr),
    .load_len  (req_len),
    .cur_addr  (cur_addr),
    .last      (last)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rd_pending <= 1'b0;
    end else begin
      state      <= next;
      rd_pending <= ram_cen & ~ram_wen;
    end
  end
  always_comb begin
    next        = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    cen         = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    load        = 1'b0;
    advance     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        load      = req_valid;
        next      = req_valid ? (req_write ? WRITE : READ) : IDLE;
      end
      WRITE: begin
        wdata_ready = 1'b1;
        cen         = wdata_valid;
        ram_wen     = 1'b1;
        ram_addr    = cur_addr;
        ram_din     = wdata;
        advance     = wdata_valid;
        next        = (wdata_valid && last) ? DONE : WRITE;
      end
      READ: begin
        cen      = 1'b1;
        ram_addr = cur_addr;
        advance  = 1'b1;
        next     = last ? RDRAIN : READ;
      end
      RDRAIN: next = DONE;
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end
  assign ram_cen     = cen & ~reset;
  assign rdata_valid = rd_pending;
  assign rdata       = rd_pending ? ram_dout : '0;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed self-checking bench with a behavioural 64x32 registered-output RAM
module tb_ram_burst_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, wdata_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [2:0]  req_len = '0;
  logic [31:0] wdata = '0;
  logic        req_ready, wdata_ready, rdata_valid, done, ram_cen, ram_wen;
  logic [31:0] rdata, ram_din;
  logic [15:0] ram_addr;
  logic [31:0] ram_dout = '0;
  logic [31:0] mem [64];
  int          checks = 0, failures = 0;
  ram_burst_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .ram_cen     (ram_cen),
    .ram_wen     (ram_wen),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (ram_cen) begin
      if (ram_wen) mem[ram_addr[5:0]] <= ram_din;
      else ram_dout <= mem[ram_addr[5:0]];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic smp;
    @(negedge clk);
  endtask
  task automatic issue(input logic w, input logic [15:0] a, input logic [2:0] l);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    step();
    req_valid = 1'b0;
  endtask
  initial begin
    int          n_cen, n_done, b;
    logic [5:0]  wrap [8];
    logic        pv [6];
    wrap = '{6'd60, 6'd61, 6'd62, 6'd63, 6'd0, 6'd1, 6'd2, 6'd3};
    pv   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    wdata_valid = 1'b1;
    step();
    smp();
    chk("rst_cen_during", ram_cen, 0);
    step();
    reset = 1'b0;
    smp();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cen", ram_cen, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rdata", rdata, 0);
    wdata = 32'hDEADBEEF;
    issue(1'b1, 16'd5, 3'd0);
    smp();
    chk("w1_cen", ram_cen, 1);
    chk("w1_wen", ram_wen, 1);
    chk("w1_addr", ram_addr, 5);
    chk("w1_din", ram_din, 32'hDEADBEEF);
    chk("w1_wready", wdata_ready, 1);
    step();
    wdata_valid = 1'b0;
    smp();
    chk("w1_done", done, 1);
    chk("w1_cen_done", ram_cen, 0);
    chk("w1_ready_done", req_ready, 0);
    step();
    smp();
    chk("w1_ready_back", req_ready, 1);
    chk("w1_done_low", done, 0);
    issue(1'b0, 16'd5, 3'd0);
    smp();
    chk("r1_cen", ram_cen, 1);
    chk("r1_wen", ram_wen, 0);
    chk("r1_addr", ram_addr, 5);
    chk("r1_rvalid_early", rdata_valid, 0);
    step();
    smp();
    chk("r1_rvalid", rdata_valid, 1);
    chk("r1_rdata", rdata, 32'hDEADBEEF);
    chk("r1_cen_drain", ram_cen, 0);
    step();
    smp();
    chk("r1_done", done, 1);
    chk("r1_rvalid_done", rdata_valid, 0);
    step();
    smp();
    chk("r1_ready_back", req_ready, 1);
    wdata = 32'd0;
    wdata_valid = 1'b1;
    issue(1'b1, 16'h003C, 3'd7);
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("bw_cen", ram_cen, 1);
      chk("bw_addr", ram_addr, {10'd0, wrap[i]});
      chk("bw_din", ram_din, i);
      step();
      wdata = i + 1;
      if (i == 7) wdata_valid = 1'b0;
    end
    smp();
    chk("bw_done", done, 1);
    step();
    smp();
    chk("bw_ready_back", req_ready, 1);
    issue(1'b0, 16'h003C, 3'd7);
    for (int k = 1; k <= 9; k++) begin
      smp();
      if (k <= 8) begin
        chk("br_cen", ram_cen, 1);
        chk("br_addr", ram_addr, {10'd0, wrap[k-1]});
      end else chk("br_cen_drain", ram_cen, 0);
      if (k >= 2) begin
        chk("br_rvalid", rdata_valid, 1);
        chk("br_rdata", rdata, k - 2);
      end else chk("br_rvalid_early", rdata_valid, 0);
      chk("br_no_done", done, 0);
      step();
    end
    smp();
    chk("br_done", done, 1);
    step();
    smp();
    chk("br_ready_back", req_ready, 1);
    n_cen = 0;
    b = 0;
    wdata = 32'hA0;
    wdata_valid = 1'b1;
    issue(1'b1, 16'h0010, 3'd3);
    for (int c = 0; c < 6; c++) begin
      smp();
      chk("st_cen", ram_cen, pv[c]);
      if (pv[c]) chk("st_addr", ram_addr, 16'h0010 + b);
      n_cen += ram_cen;
      step();
      if (pv[c]) b++;
      wdata_valid = (c < 5) ? pv[c+1] : 1'b0;
      wdata = 32'hA0 + b;
    end
    smp();
    chk("st_done", done, 1);
    chk("st_writes", n_cen, 4);
    chk("st_mem0", mem[16], 32'hA0);
    chk("st_mem3", mem[19], 32'hA3);
    step();
    smp();
    chk("st_ready_back", req_ready, 1);
    n_cen = 0;
    n_done = 0;
    wdata = 32'h55;
    wdata_valid = 1'b1;
    issue(1'b1, 16'h0020, 3'd2);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 4) && (c % 2 == 0);
      req_write = 1'b0;
      req_addr  = 16'h0030;
      smp();
      n_cen  += ram_cen;
      n_done += done;
      if (c < 4) chk("ig_ready_busy", req_ready, 0);
      step();
    end
    req_valid = 1'b0;
    wdata_valid = 1'b0;
    chk("ig_accesses", n_cen, 3);
    chk("ig_dones", n_done, 1);
    chk("ig_mem", mem[34], 32'h55);
    issue(1'b0, 16'h0000, 3'd7);
    for (int c = 0; c < 3; c++) begin
      smp();
      chk("rm_cen", ram_cen, 1);
      step();
    end
    reset = 1'b1;
    smp();
    chk("rm_cen_reset", ram_cen, 0);
    step();
    reset = 1'b0;
    smp();
    chk("rm_rvalid", rdata_valid, 0);
    chk("rm_ready", req_ready, 1);
    chk("rm_done", done, 0);
    n_cen = 0;
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      smp();
      n_cen  += ram_cen;
      n_done += done;
    end
    chk("rm_no_done", n_done, 0);
    chk("rm_no_access", n_cen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
